// File: rtl/inta_sequencer_pkg.sv
// Shared types and helpers for the 8259A INTA sequencer slice.
package pic_pkg;

    localparam int unsigned PIC_NUM_IR = 8;

    localparam logic MASTER = 1'b1;
    localparam logic SLAVE  = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK1,
        WAIT2,
        ACK2
    } seq_state_t;

    // Interrupt vector byte: vector base from ICW2 with the IR level in the low bits.
    function automatic logic [7:0] make_vector(input logic [7:0] icw2, input logic [2:0] lvl);
        return {icw2[7:3], lvl};
    endfunction

endpackage

// File: rtl/inta_sequencer_if.sv
// Handshake/bus bundle between the INTA sequencer and its neighbours
// (priority resolver, cascade controller, CPU data bus).
interface inta_sequencer_if;
    import pic_pkg::*;

    logic                  inta_n;
    logic                  req_valid;
    logic [2:0]            req_level;
    logic                  slave_match;
    logic                  int_out;
    logic                  cas_strobe;
    logic [2:0]            desired_slave;
    logic [PIC_NUM_IR-1:0] isr_set;
    logic [7:0]            data_out;
    logic                  data_oe;

    // Sequencer side.
    modport master (
        input  inta_n,
        input  req_valid,
        input  req_level,
        input  slave_match,
        output int_out,
        output cas_strobe,
        output desired_slave,
        output isr_set,
        output data_out,
        output data_oe
    );

    // Environment side.
    modport slave (
        output inta_n,
        output req_valid,
        output req_level,
        output slave_match,
        input  int_out,
        input  cas_strobe,
        input  desired_slave,
        input  isr_set,
        input  data_out,
        input  data_oe
    );

endinterface

// File: rtl/inta_sequencer_edge_detect.sv
// INTA_n edge detector: keeps a registered copy of INTA_n and flags
// falling/rising samples relative to the current input.
module inta_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic inta_n_i,
    output logic fall_o,
    output logic rise_o
);

    logic inta_q;

    // Previous INTA_n sample; idles high like the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            inta_q <= 1'b1;
        end else begin
            inta_q <= inta_n_i;
        end
    end

    assign fall_o = inta_q & ~inta_n_i;
    assign rise_o = ~inta_q & inta_n_i;

endmodule

// File: rtl/inta_sequencer.sv
// INTA sequencer for the 8259A PIC: raises INT, tracks the two-pulse
// INTA_n cycle, strobes the cascade controller, pulses the ISR set and
// drives the vector byte.
// Optional feature macro: PIC_AUTO_EOI_EN (adds aeoi / eoi_valid / eoi_level).
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int unsigned NUM_IR = 8
) (
    input  logic              clk,
    input  logic              reset,
`ifdef PIC_AUTO_EOI_EN
    input  logic              aeoi,
    output logic              eoi_valid,
    output logic [2:0]        eoi_level,
`endif
    input  logic              sp,
    input  logic [7:0]        icw2,
    input  logic [NUM_IR-1:0] icw3,
    inta_sequencer_if.master  bus
);

    seq_state_t        state_q, state_d;
    logic [2:0]        lvl_q, lvl_d;
    logic              spur_q, spur_d;
    logic              int_out_q, int_out_d;
    logic              cas_strobe_q, cas_strobe_d;
    logic [NUM_IR-1:0] isr_set_q, isr_set_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              data_oe_q, data_oe_d;
`ifdef PIC_AUTO_EOI_EN
    logic              eoi_valid_q, eoi_valid_d;
    logic [2:0]        eoi_level_q, eoi_level_d;
`endif

    logic fall;
    logic rise;
    logic oe_allowed;

    inta_edge_detect u_edge (
        .clk      (clk),
        .reset    (reset),
        .inta_n_i (bus.inta_n),
        .fall_o   (fall),
        .rise_o   (rise)
    );

    // A master stays off the bus when a cascaded slave owns this level;
    // a slave drives only when the cascade controller matched its ID.
    assign oe_allowed = (sp == MASTER) ? ~icw3[lvl_q] : bus.slave_match;

    // State and output registers; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            lvl_q        <= '0;
            spur_q       <= 1'b0;
            int_out_q    <= 1'b0;
            cas_strobe_q <= 1'b0;
            isr_set_q    <= '0;
            data_out_q   <= '0;
            data_oe_q    <= 1'b0;
`ifdef PIC_AUTO_EOI_EN
            eoi_valid_q  <= 1'b0;
            eoi_level_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            lvl_q        <= lvl_d;
            spur_q       <= spur_d;
            int_out_q    <= int_out_d;
            cas_strobe_q <= cas_strobe_d;
            isr_set_q    <= isr_set_d;
            data_out_q   <= data_out_d;
            data_oe_q    <= data_oe_d;
`ifdef PIC_AUTO_EOI_EN
            eoi_valid_q  <= eoi_valid_d;
            eoi_level_q  <= eoi_level_d;
`endif
        end
    end

    // Next-state and registered-output decode; pulses default low each cycle.
    always_comb begin
        state_d      = state_q;
        lvl_d        = lvl_q;
        spur_d       = spur_q;
        int_out_d    = int_out_q;
        cas_strobe_d = 1'b0;
        isr_set_d    = '0;
        data_out_d   = data_out_q;
        data_oe_d    = data_oe_q;
`ifdef PIC_AUTO_EOI_EN
        eoi_valid_d  = 1'b0;
        eoi_level_d  = eoi_level_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d   = REQ;
                    int_out_d = 1'b1;
                end
            end
            REQ: begin
                if (fall) begin
                    // ACK1 entry values are registered here so that they appear
                    // exactly in the first ACK1 cycle; a vanished request
                    // becomes spurious IR7.
                    state_d      = ACK1;
                    int_out_d    = 1'b0;
                    cas_strobe_d = 1'b1;
                    spur_d       = ~bus.req_valid;
                    lvl_d        = bus.req_valid ? bus.req_level : 3'd7;
                    if (bus.req_valid) begin
                        for (int unsigned i = 0; i < NUM_IR; i++) begin
                            isr_set_d[i] = (32'(bus.req_level) == i);
                        end
                    end
                end
            end
            ACK1: begin
                if (rise) begin
                    state_d = WAIT2;
                end
            end
            WAIT2: begin
                if (fall) begin
                    state_d    = ACK2;
                    data_oe_d  = oe_allowed;
                    data_out_d = oe_allowed ? make_vector(icw2, lvl_q) : '0;
                end
            end
            ACK2: begin
                if (rise) begin
                    state_d    = IDLE;
                    data_oe_d  = 1'b0;
                    data_out_d = '0;
`ifdef PIC_AUTO_EOI_EN
                    eoi_valid_d = aeoi & ~spur_q;
                    eoi_level_d = lvl_q;
`else
                    // ISR clearing is handled by the OCW2 EOI path.
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.int_out       = int_out_q;
    assign bus.cas_strobe    = cas_strobe_q;
    assign bus.desired_slave = lvl_q;
    assign bus.isr_set       = isr_set_q;
    assign bus.data_out      = data_out_q;
    assign bus.data_oe       = data_oe_q;
`ifdef PIC_AUTO_EOI_EN
    assign eoi_valid         = eoi_valid_q;
    assign eoi_level         = eoi_level_q;
`endif

endmodule

// File: tb/tb_inta_sequencer.sv
// Scoreboard bench for inta_sequencer: the driver pushes the expected
// acknowledge outcome per transaction, a negedge monitor pops and compares.
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       sp;
    logic [7:0] icw2;
    logic [7:0] icw3;
`ifdef PIC_AUTO_EOI_EN
    logic       aeoi;
    logic       eoi_valid;
    logic [2:0] eoi_level;
`endif

    inta_sequencer_if bus ();

    inta_sequencer #(.NUM_IR(8)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef PIC_AUTO_EOI_EN
        .aeoi      (aeoi),
        .eoi_valid (eoi_valid),
        .eoi_level (eoi_level),
`endif
        .sp    (sp),
        .icw2  (icw2),
        .icw3  (icw3),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] lvl;
        logic [7:0] isr;
        logic [7:0] vec;
        int         oe_cycles;
        int         eoi_pulses;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   cur_v = 1'b0;
    int   oe_seen;
    int   eoi_seen;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic finalize();
        if (cur_v) begin
            check("oe_cycles", oe_seen, cur.oe_cycles);
`ifdef PIC_AUTO_EOI_EN
            check("eoi_pulses", eoi_seen, cur.eoi_pulses);
`endif
            cur_v = 1'b0;
        end
    endtask

    // Monitor: consume one expectation per cas_strobe, then watch the data phase.
    always @(negedge clk) begin
        if (reset) begin
            cur_v = 1'b0;
        end else begin
            if (bus.cas_strobe) begin
                finalize();
                check("cas_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur      = exp_q.pop_front();
                    cur_v    = 1'b1;
                    oe_seen  = 0;
                    eoi_seen = 0;
                    check("isr_set", bus.isr_set, cur.isr);
                end
            end else begin
                check("isr_quiet", bus.isr_set, 0);
            end
            if (cur_v) begin
                check("desired_slave", bus.desired_slave, cur.lvl);
            end
            if (bus.data_oe) begin
                check("oe_owner", cur_v, 1);
                if (cur_v) begin
                    oe_seen++;
                    check("data_out", bus.data_out, cur.vec);
                end
            end
`ifdef PIC_AUTO_EOI_EN
            if (eoi_valid) begin
                check("eoi_owner", cur_v, 1);
                if (cur_v) begin
                    eoi_seen++;
                    check("eoi_level", eoi_level, cur.lvl);
                end
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_int"}, bus.int_out, 0);
        check({tag, "_cas"}, bus.cas_strobe, 0);
        check({tag, "_ds"}, bus.desired_slave, 0);
        check({tag, "_isr"}, bus.isr_set, 0);
        check({tag, "_dout"}, bus.data_out, 0);
        check({tag, "_oe"}, bus.data_oe, 0);
`ifdef PIC_AUTO_EOI_EN
        check({tag, "_eoi"}, eoi_valid, 0);
`endif
    endtask

    // One full two-pulse acknowledge, with the expected outcome taken from the
    // behavioural rules: spurious -> IR7 without ISR set; vector = base|level;
    // bus ownership by mode; auto-EOI for real requests only.
    task automatic run_txn(input bit m_sp, input logic [7:0] i2, input logic [7:0] i3,
                           input logic [2:0] lvl, input bit spur, input bit sm, input bit ae);
        exp_t e;
        int   d0, h1, g, h2;
        logic [2:0] el;
        bit   oe;
        d0 = $urandom_range(0, 3);
        h1 = $urandom_range(1, 3);
        g  = $urandom_range(1, 3);
        h2 = $urandom_range(1, 3);
        sp = m_sp; icw2 = i2; icw3 = i3;
        bus.slave_match = sm;
`ifdef PIC_AUTO_EOI_EN
        aeoi = ae;
`endif
        bus.req_level = lvl;
        bus.req_valid = 1'b1;
        check("int_pre", bus.int_out, 0);
        tick();
        check("int_rise", bus.int_out, 1);
        if (spur) bus.req_valid = 1'b0;
        repeat (d0) tick();
        check("int_hold", bus.int_out, 1);

        el = spur ? 3'd7 : lvl;
        oe = m_sp ? !i3[el] : sm;
        e.lvl        = el;
        e.isr        = spur ? 8'h00 : (8'h01 << lvl);
        e.vec        = {i2[7:3], el};
        e.oe_cycles  = oe ? h2 : 0;
        e.eoi_pulses = (ae && !spur) ? 1 : 0;
        exp_q.push_back(e);

        bus.inta_n = 1'b0;
        tick();
        check("int_release", bus.int_out, 0);
        bus.req_valid = 1'b0;
        bus.req_level = 3'($urandom);
        repeat (h1 - 1) tick();
        bus.inta_n = 1'b1;
        repeat (g) tick();
        bus.inta_n = 1'b0;
        repeat (h2) tick();
        bus.inta_n = 1'b1;
        repeat (3) tick();
    endtask

    // Third INTA pulse with nothing pending: must be ignored.
    task automatic idle_pulse();
        bus.req_valid = 1'b0;
        bus.inta_n = 1'b0;
        repeat (2) tick();
        bus.inta_n = 1'b1;
        repeat (2) tick();
        check("idle_int", bus.int_out, 0);
    endtask

    task automatic reset_in_wait2();
        exp_t e;
        sp = 1'b1; icw2 = 8'h40; icw3 = 8'h00;
        bus.req_level = 3'd1;
        bus.req_valid = 1'b1;
        tick();
        e.lvl = 3'd1; e.isr = 8'h02; e.vec = 8'h41; e.oe_cycles = 0; e.eoi_pulses = 0;
        exp_q.push_back(e);
        bus.inta_n = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        bus.inta_n = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check_all_zero("rst_wait2");
        reset = 1'b0;
        tick();
        idle_pulse();
    endtask

    initial begin
        reset = 1'b1;
        sp = 1'b1; icw2 = '0; icw3 = '0;
`ifdef PIC_AUTO_EOI_EN
        aeoi = 1'b0;
`endif
        bus.inta_n = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_level = '0;
        bus.slave_match = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        run_txn(1'b1, 8'h40, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0);
        run_txn(1'b1, 8'h40, 8'h04, 3'd2, 1'b0, 1'b0, 1'b0);
        run_txn(1'b0, 8'h70, 8'h00, 3'd5, 1'b0, 1'b1, 1'b0);
        run_txn(1'b0, 8'h70, 8'h00, 3'd5, 1'b0, 1'b0, 1'b0);
        run_txn(1'b1, 8'h40, 8'h00, 3'd4, 1'b1, 1'b0, 1'b1);
        run_txn(1'b1, 8'h40, 8'h00, 3'd6, 1'b0, 1'b0, 1'b1);
        idle_pulse();
        reset_in_wait2();

        for (int n = 0; n < 60; n++) begin
            run_txn(1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom),
                    ($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 5) == 0) idle_pulse();
        end

        tick();
        finalize();
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
